bram_requester: RTL and testbench

Initiator-side port controller for the single-port-pair `BRAM` block: accepts load/store requests from a core or cache over a valid/ready handshake, drives the BRAM read and write port signals, absorbs the BRAM's one-cycle read latency, and returns load data through a 4-entry response FIFO with its own valid/ready handshake. It sits between a core memory stage and one `BRAM` instance, so upstream logic never tracks BRAM timing or stalls on response backpressure mid-flight.

---
 rtl/bram_requester.sv | 134 +++++++++++++
 tb/tb_bram_requester.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_requester.sv
// bram_requester: load/store front end for one BRAM instance.
// Requests arrive over valid/ready, drive the BRAM ports combinationally,
// and load data returns through a 4-entry response FIFO. A credit count
// (FIFO occupancy + load in flight) gates new requests, so the FIFO can
// never overflow.
// Optional: define BRAM_REQUESTER_SCAN_EN for a per-cycle debug print.
module bram_requester #(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 8,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  requestValid,
  output logic                  requestReady,
  input  logic                  requestWrite,
  input  logic [ADDR_WIDTH-1:0] requestAddress,
  input  logic [DATA_WIDTH-1:0] requestData,
  output logic                  responseValid,
  input  logic                  responseReady,
  output logic [DATA_WIDTH-1:0] responseData,
  output logic                  readEnable,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [DATA_WIDTH-1:0] writeData,
  input  logic                  scan
);

  localparam int DEPTH = 4;

  logic [DATA_WIDTH-1:0] fifo_q [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [DEPTH];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            fifo_count_q, fifo_count_d;
  logic                  in_flight_q, in_flight_d;

  logic [2:0] used;
  logic       accept;
  logic       push;
  logic       pop;

  // Credits: every accepted load owns a FIFO slot until it is popped.
  // Ready looks only at registered state, never at the request type or
  // at responseReady.
  always_comb begin
    used         = fifo_count_q + {2'b00, in_flight_q};
    requestReady = ~reset & (used < 3'd4);
    accept       = requestValid & requestReady;
    readEnable   = accept & ~requestWrite;
    writeEnable  = accept & requestWrite;
    readAddress  = requestAddress;
    writeAddress = requestAddress;
    writeData    = requestData;
  end

  assign responseValid = (fifo_count_q != 3'd0);
  assign responseData  = fifo_q[rd_ptr_q];

  // BRAM data is valid the cycle after an accepted load: capture it then.
  assign push = in_flight_q;
  assign pop  = responseValid & responseReady;

  // Next-state for in-flight flag, FIFO storage, pointers and occupancy.
  always_comb begin
    in_flight_d  = readEnable;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = readData;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    unique case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + 3'd1;
      2'b01:   fifo_count_d = fifo_count_q - 3'd1;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // State register; reset drops any load still returning from the BRAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      in_flight_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      in_flight_q  <= in_flight_d;
    end
  end

`ifdef BRAM_REQUESTER_SCAN_EN
  logic [31:0] cycles_q, cycles_d;

  // Free-running cycle counter used to window the debug print.
  always_comb begin
    cycles_d = cycles_q + 32'd1;
  end

  // Cycle counter register.
  always_ff @(posedge clock) begin
    if (reset) cycles_q <= '0;
    else       cycles_q <= cycles_d;
  end

  // Debug print of request, credit and response state.
  always_ff @(posedge clock) begin
    if (scan && (cycles_q >= SCAN_CYCLES_MIN) && (cycles_q <= SCAN_CYCLES_MAX)) begin
      $display("core %0d cycle %0d req v=%0b r=%0b w=%0b a=%h d=%h used=%0d inflight=%0b resp v=%0b d=%h",
               CORE, cycles_q, requestValid, requestReady, requestWrite,
               requestAddress, requestData, used, in_flight_q,
               responseValid, responseData);
    end
  end
`else
  logic scan_unused;
  assign scan_unused = scan & (CORE >= 0) & (SCAN_CYCLES_MIN <= SCAN_CYCLES_MAX);
`endif

endmodule

// File: tb/tb_bram_requester.sv
// Bench for bram_requester: a BRAM model with one-cycle read latency, a
// request-level reference (memory array + queue of pending load results)
// checked every cycle, and directed scenarios with literal expectations.
module tb_bram_requester;

  logic        clock = 1'b0;
  logic        reset;
  logic        requestValid, requestReady, requestWrite;
  logic [7:0]  requestAddress;
  logic [31:0] requestData;
  logic        responseValid, responseReady;
  logic [31:0] responseData;
  logic        readEnable, writeEnable;
  logic [7:0]  readAddress, writeAddress;
  logic [31:0] readData, writeData;
  logic        scan;

  bram_requester dut (
    .clock(clock), .reset(reset),
    .requestValid(requestValid), .requestReady(requestReady),
    .requestWrite(requestWrite), .requestAddress(requestAddress),
    .requestData(requestData),
    .responseValid(responseValid), .responseReady(responseReady),
    .responseData(responseData),
    .readEnable(readEnable), .readAddress(readAddress), .readData(readData),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
    .scan(scan)
  );

  always #5 clock = ~clock;

  // BRAM: synchronous write, registered read.
  logic [31:0] bram [256];
  always @(posedge clock) begin
    if (writeEnable) bram[writeAddress] <= writeData;
    if (readEnable)  readData <= bram[readAddress];
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: every accepted load is owed a response holding the memory
  // value at accept time, visible no earlier than two cycles later; at most
  // four may be owed at once.
  logic [31:0] ref_mem [256];
  logic [31:0] q_data [$];
  int          q_cyc [$];
  logic [31:0] resp_log [$];
  int          resp_cyc [$];
  int          cyc = 0;
  int          n_acc = 0;
  int          ready_low = 0;
  bit          exp_ready, exp_valid;

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      chk("ready_in_reset", {31'b0, requestReady}, 32'd0);
      chk("bram_en_in_reset", {30'b0, readEnable, writeEnable}, 32'd0);
      q_data.delete();
      q_cyc.delete();
    end else begin
      exp_ready = (q_data.size() < 4);
      exp_valid = (q_data.size() > 0) && (q_cyc[0] <= cyc - 2);
      chk("requestReady", {31'b0, requestReady}, {31'b0, exp_ready});
      chk("responseValid", {31'b0, responseValid}, {31'b0, exp_valid});
      if (exp_valid) chk("responseData", responseData, q_data[0]);
      chk("bram_en", {30'b0, readEnable, writeEnable},
          {30'b0, requestValid & exp_ready & ~requestWrite, requestValid & exp_ready & requestWrite});
      if (!requestReady) ready_low++;
      if (exp_valid && responseReady) begin
        resp_log.push_back(q_data[0]);
        resp_cyc.push_back(cyc);
        void'(q_data.pop_front());
        void'(q_cyc.pop_front());
      end
      if (requestValid && requestReady) begin
        n_acc++;
        if (requestWrite) ref_mem[requestAddress] = requestData;
        else begin
          q_data.push_back(ref_mem[requestAddress]);
          q_cyc.push_back(cyc);
        end
      end
    end
  end

  // Offer one request and hold it until accepted (bounded wait).
  task automatic do_req(input bit w, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    requestValid = 1'b1; requestWrite = w; requestAddress = a; requestData = d;
    @(negedge clock);
    while (!requestReady && n < 60) begin @(negedge clock); n++; end
    if (n >= 60) begin n_err++; $display("FAIL req_timeout: got no accept expected accept"); end
    @(posedge clock); #1;
    requestValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  bit rand_rr = 0;
  initial begin
    forever begin
      @(posedge clock); #1;
      if (rand_rr) responseReady = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int acc0, lo0, p0;

  initial begin
    for (int i = 0; i < 256; i++) begin bram[i] = 32'h0; ref_mem[i] = 32'h0; end
    reset = 1'b1; requestValid = 1'b0; requestWrite = 1'b0; requestAddress = '0;
    requestData = '0; responseReady = 1'b1; scan = 1'b0;
    idle(3);
    @(negedge clock);
    chk("reset_resp_valid", {31'b0, responseValid}, 32'd0);
    chk("reset_resp_data", responseData, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Store then load of the same address on the next cycle.
    do_req(1'b1, 8'h10, 32'hDEADBEEF);
    do_req(1'b0, 8'h10, 32'h0);
    @(negedge clock);
    chk("st_ld_valid_t1", {31'b0, responseValid}, 32'd0);
    @(negedge clock);
    chk("st_ld_valid_t2", {31'b0, responseValid}, 32'd1);
    chk("st_ld_data", responseData, 32'hDEADBEEF);
    idle(2);

    // Preload 0x00..0x0F then 16 back-to-back loads.
    for (int i = 0; i < 16; i++) do_req(1'b1, 8'(i), 32'(i));
    idle(2);
    resp_log.delete(); resp_cyc.delete();
    lo0 = ready_low;
    for (int i = 0; i < 16; i++) do_req(1'b0, 8'(i), 32'h0);
    idle(4);
    chk("b2b_ready_never_low", 32'(ready_low - lo0), 32'd0);
    chk("b2b_resp_count", 32'(resp_log.size()), 32'd16);
    if (resp_log.size() == 16) begin
      for (int i = 0; i < 16; i++) chk("b2b_resp_data", resp_log[i], 32'(i));
      chk("b2b_one_per_cycle", 32'(resp_cyc[15] - resp_cyc[0]), 32'd15);
    end

    // Backpressure: 6 loads offered with responseReady low.
    responseReady = 1'b0;
    acc0 = n_acc;
    resp_log.delete();
    fork
      for (int i = 0; i < 6; i++) do_req(1'b0, 8'(i + 2), 32'h0);
      begin
        repeat (10) @(negedge clock);
        chk("bp_accepted", 32'(n_acc - acc0), 32'd4);
        chk("bp_ready_low", {31'b0, requestReady}, 32'd0);
        @(posedge clock); #1;
        responseReady = 1'b1;
      end
    join
    idle(6);
    chk("bp_resp_count", 32'(resp_log.size()), 32'd6);
    if (resp_log.size() == 6)
      for (int i = 0; i < 6; i++) chk("bp_resp_data", resp_log[i], 32'(i + 2));

    // Push and pop together with three entries held.
    responseReady = 1'b0;
    for (int i = 0; i < 3; i++) do_req(1'b0, 8'(i + 7), 32'h0);
    idle(3);
    do_req(1'b0, 8'h0A, 32'h0);
    responseReady = 1'b1;   // pop during the cycle the 4th load is pushed
    @(posedge clock); #1;
    responseReady = 1'b0;
    @(negedge clock);
    chk("pp_ready_at_3", {31'b0, requestReady}, 32'd1);
    chk("pp_head_data", responseData, 32'h8);
    p0 = resp_log.size();
    responseReady = 1'b1;
    idle(5);
    chk("pp_drain_count", 32'(resp_log.size() - p0), 32'd3);

    // Reset one cycle after a load is accepted.
    do_req(1'b0, 8'h05, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_ready_low", {31'b0, requestReady}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready_after", {31'b0, requestReady}, 32'd1);
    chk("rst_no_valid", {31'b0, responseValid}, 32'd0);
    chk("rst_head_zero", responseData, 32'd0);
    p0 = resp_log.size();
    idle(4);
    chk("rst_no_resp", 32'(resp_log.size() - p0), 32'd0);

    // Random mix with random response backpressure.
    rand_rr = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
    end
    rand_rr = 0;
    #1 responseReady = 1'b1;
    idle(10);
    chk("rand_drained", 32'(q_data.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
